// File: rtl/lifo_stack_pkg.sv
// Shared types for the LIFO stack: per-cycle operation decode.
package lifo_stack_pkg;

    typedef enum logic [1:0] {
        OP_IDLE,
        OP_PUSH,
        OP_POP,
        OP_SWAP
    } op_e;

    // Requests that cannot complete (push on full, pop on empty) become idle;
    // push+pop on an empty stack degrades to a plain push.
    function automatic op_e decode_op(input logic push, input logic pop,
                                      input logic empty, input logic full);
        op_e op;
        op = OP_IDLE;
        if (push && pop) begin
            op = empty ? OP_PUSH : OP_SWAP;
        end else if (push) begin
            if (!full) op = OP_PUSH;
        end else if (pop) begin
            if (!empty) op = OP_POP;
        end
        return op;
    endfunction

endpackage

// File: rtl/lifo_stack_ram.sv
// Stack storage: register array with one synchronous write and one async read.
module lifo_stack_ram #(
    parameter int DATA_SIZE = 8,
    parameter int ADDR_W    = 4
) (
    input  logic                 clk,
    input  logic                 wr_en,
    input  logic [ADDR_W-1:0]    wr_addr,
    input  logic [DATA_SIZE-1:0] wr_data,
    input  logic [ADDR_W-1:0]    rd_addr,
    output logic [DATA_SIZE-1:0] rd_data
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_SIZE-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/lifo_stack.sv
// LIFO stack top: occupancy count, flags and the registered pop-data output.
module lifo_stack
    import lifo_stack_pkg::*;
#(
    parameter int DATA_SIZE      = 8,
    parameter int ADDR_SPACE_EXP = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push,
    input  logic                 pop,
    input  logic [DATA_SIZE-1:0] push_data_in,
    output logic [DATA_SIZE-1:0] pop_data_out,
    output logic                 empty,
    output logic                 full
);

    localparam int AW    = ADDR_SPACE_EXP;
    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE     = (AW+1)'(1);

    logic [AW:0]          count;
    logic [AW:0]          top_idx;
    logic [AW-1:0]        wr_addr;
    logic [DATA_SIZE-1:0] rd_data;
    logic                 wr_en;
    op_e                  op;

    assign empty   = (count == '0);
    assign full    = (count == DEPTH_C);
    assign op      = decode_op(push, pop, empty, full);
    assign top_idx = count - ONE;

    // A swap overwrites the current top; a push fills the next free slot.
    assign wr_en   = (op == OP_PUSH) || (op == OP_SWAP);
    assign wr_addr = (op == OP_SWAP) ? top_idx[AW-1:0] : count[AW-1:0];

    lifo_stack_ram #(
        .DATA_SIZE (DATA_SIZE),
        .ADDR_W    (AW)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (push_data_in),
        .rd_addr (top_idx[AW-1:0]),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count        <= '0;
            pop_data_out <= '0;
        end else begin
            case (op)
                OP_PUSH: count <= count + ONE;
                OP_POP: begin
                    count        <= top_idx;
                    pop_data_out <= rd_data;
                end
                OP_SWAP: pop_data_out <= rd_data;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lifo_stack.sv
// Directed vector table plus async-reset and reference-model sequences for lifo_stack.
module tb_lifo_stack;

    localparam int DW  = 8;
    localparam int AE  = 2;
    localparam int DEP = 1 << AE;

    logic          clk = 1'b0;
    logic          reset;
    logic          push, pop;
    logic [DW-1:0] push_data_in;
    logic [DW-1:0] pop_data_out;
    logic          empty, full;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lifo_stack #(.DATA_SIZE(DW), .ADDR_SPACE_EXP(AE)) dut (
        .clk          (clk),
        .reset        (reset),
        .push         (push),
        .pop          (pop),
        .push_data_in (push_data_in),
        .pop_data_out (pop_data_out),
        .empty        (empty),
        .full         (full)
    );

    typedef struct {
        logic          push;
        logic          pop;
        logic [DW-1:0] din;
        logic [DW-1:0] dout;
        logic          empty;
        logic          full;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [DW-1:0] d, input logic e, input logic f);
        check({tag, ".dout"},  pop_data_out, d);
        check({tag, ".empty"}, DW'(empty), DW'(e));
        check({tag, ".full"},  DW'(full), DW'(f));
    endtask

    task automatic step(input logic pu, input logic po, input logic [DW-1:0] d);
        @(negedge clk);
        push = pu; pop = po; push_data_in = d;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; push = 1'b0; pop = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    function automatic vec_t mk(input logic pu, input logic po, input logic [DW-1:0] d,
                                input logic [DW-1:0] q, input logic e, input logic f);
        vec_t v;
        v.push = pu; v.pop = po; v.din = d; v.dout = q; v.empty = e; v.full = f;
        return v;
    endfunction

    logic [DW-1:0] mdl_mem [DEP];
    int            mdl_cnt;
    logic [DW-1:0] mdl_out;

    initial begin
        reset = 1'b1; push = 1'b0; pop = 1'b0; push_data_in = '0;

        //          push pop din    dout   empty full
        vecs.push_back(mk(1, 0, 8'h00, 8'h00, 0, 0));
        vecs.push_back(mk(1, 0, 8'hF0, 8'h00, 0, 0));
        vecs.push_back(mk(1, 0, 8'h0F, 8'h00, 0, 0));
        vecs.push_back(mk(1, 0, 8'hAA, 8'h00, 0, 1));
        vecs.push_back(mk(1, 0, 8'h55, 8'h00, 0, 1)); // push on full ignored
        vecs.push_back(mk(0, 1, 8'h00, 8'hAA, 0, 0));
        vecs.push_back(mk(0, 1, 8'h00, 8'h0F, 0, 0));
        vecs.push_back(mk(0, 1, 8'h00, 8'hF0, 0, 0));
        vecs.push_back(mk(0, 1, 8'h00, 8'h00, 1, 0));
        vecs.push_back(mk(0, 1, 8'h00, 8'h00, 1, 0)); // pop on empty ignored
        vecs.push_back(mk(1, 0, 8'hBC, 8'h00, 0, 0));
        vecs.push_back(mk(1, 1, 8'h77, 8'hBC, 0, 0));
        vecs.push_back(mk(0, 1, 8'h00, 8'h77, 1, 0));
        vecs.push_back(mk(0, 0, 8'h00, 8'h77, 1, 0));
        vecs.push_back(mk(0, 0, 8'h00, 8'h77, 1, 0));
        vecs.push_back(mk(0, 0, 8'h00, 8'h77, 1, 0));
        vecs.push_back(mk(1, 1, 8'h5A, 8'h77, 0, 0)); // push+pop on empty = push
        vecs.push_back(mk(0, 1, 8'h00, 8'h5A, 1, 0));
        vecs.push_back(mk(1, 0, 8'h11, 8'h5A, 0, 0));
        vecs.push_back(mk(1, 0, 8'h22, 8'h5A, 0, 0));
        vecs.push_back(mk(1, 0, 8'h33, 8'h5A, 0, 0));
        vecs.push_back(mk(1, 0, 8'h44, 8'h5A, 0, 1));
        vecs.push_back(mk(1, 1, 8'h99, 8'h44, 0, 1)); // swap while full
        vecs.push_back(mk(0, 1, 8'h00, 8'h99, 0, 0));
        vecs.push_back(mk(0, 1, 8'h00, 8'h33, 0, 0));
        vecs.push_back(mk(0, 1, 8'h00, 8'h22, 0, 0));
        vecs.push_back(mk(0, 1, 8'h00, 8'h11, 1, 0));

        repeat (2) @(negedge clk);
        check_all("reset", 8'h00, 1'b1, 1'b0);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].push, vecs[i].pop, vecs[i].din);
            check_all($sformatf("vec%0d", i), vecs[i].dout, vecs[i].empty, vecs[i].full);
        end

        // Asynchronous reset mid-stream, asserted between clock edges.
        step(1, 0, 8'hC1);
        step(1, 0, 8'hC2);
        step(0, 1, 8'h00);
        check_all("pre_rst", 8'hC2, 1'b0, 1'b0);
        push = 1'b0; pop = 1'b0;
        #2 reset = 1'b1;
        #1 check_all("async_rst", 8'h00, 1'b1, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        step(0, 1, 8'h00);
        check_all("rst_pop_empty", 8'h00, 1'b1, 1'b0);

        // Random traffic against an independent reference model.
        do_reset();
        mdl_cnt = 0;
        mdl_out = '0;
        for (int i = 0; i < 200; i++) begin
            logic          pu, po;
            logic [DW-1:0] d;
            pu = ($urandom_range(0, 99) < 55);
            po = ($urandom_range(0, 99) < 45);
            d  = DW'($urandom);
            if (pu && po && mdl_cnt > 0) begin
                mdl_out = mdl_mem[mdl_cnt-1];
                mdl_mem[mdl_cnt-1] = d;
            end else if (pu && mdl_cnt < DEP) begin
                mdl_mem[mdl_cnt] = d;
                mdl_cnt++;
            end else if (po && !pu && mdl_cnt > 0) begin
                mdl_cnt--;
                mdl_out = mdl_mem[mdl_cnt];
            end
            step(pu, po, d);
            check_all($sformatf("rnd%0d", i), mdl_out, mdl_cnt == 0, mdl_cnt == DEP);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
